// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD, one bit per clock.
// A start in IDLE or DONE captures bin; the result lands in bcd with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | add-3 / shift iterations, one operand bit per clock
// DONE  | bcd freshly updated, done pulsed; start here chains the next operand
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  // True when DIGITS decimal digits can hold every BIN_W-bit value.
  function automatic bit cfg_ok();
    longint unsigned p   = 64'd1;
    longint unsigned lim = 64'd1 << BIN_W;
    for (int i = 0; i < DIGITS && p < lim; i++) p = p * 64'd10;
    return p >= lim;
  endfunction

  localparam bit CFG_OK = cfg_ok();

  generate
    if (!CFG_OK) begin : g_cfg_check
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WORK_W-1:0]  adj, shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // One double-dabble iteration: correct each digit >= 5, then shift the whole register.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[BIN_W+4*k +: 4] >= 4'd5) adj[BIN_W+4*k +: 4] = adj[BIN_W+4*k +: 4] + 4'd3;
    end
    shifted = {adj[WORK_W-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        work_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          bcd_d   = shifted[WORK_W-1 -: BCD_W];
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: default 8-bit/3-digit instance plus a 4-bit/2-digit one.
// Stimulus pushes expected result and done cycle; monitors pop and compare on each done.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  bin;
  logic [3:0]  bin2;
  logic        busy, done, busy2, done2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_run = 0, busy_run2 = 0;

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  bin_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit bad_digit(input logic [11:0] b);
    bit bad = 1'b0;
    for (int k = 0; k < 3; k++) if (b[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // In-flight operands die with reset; no done may follow for them.
  always @(negedge rst_n) begin
    q1.delete();
    q2.delete();
    busy_run  = 0;
    busy_run2 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_run++;
      if (done) begin
        chk("done_busy_overlap", 32'(busy), 32'd0);
        if (q1.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          chk("bcd", 32'(bcd), 32'(e1.bcd));
          chk("done_latency", cyc, e1.due);
          chk("busy_len", busy_run, 32'd8);
          chk("digit_range", 32'(bad_digit(bcd)), 32'd0);
        end
        busy_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy2) busy_run2++;
      if (done2) begin
        if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
        else begin
          e2 = q2.pop_front();
          chk("bcd2", 32'(bcd2), 32'(e2.bcd[7:0]));
          chk("done_latency2", cyc, e2.due);
          chk("busy_len2", busy_run2, 32'd4);
        end
        busy_run2 = 0;
      end
    end
  end

  // Start accepted on the coming edge (cyc+1); done seen BIN_W edges later.
  task automatic issue(input logic [7:0] v, input logic [11:0] exp);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    q1.push_back('{exp, cyc + 9});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue2(input logic [3:0] v, input logic [7:0] exp);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = v;
    q2.push_back('{{4'd0, exp}, cyc + 5});
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      chk("drain_timeout", 32'(q1.size() + q2.size()), 32'd0);
      q1.delete();
      q2.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [7:0]  dir_bin [4] = '{8'd0, 8'd255, 8'd99, 8'd10};
  logic [11:0] dir_bcd [4] = '{12'h000, 12'h255, 12'h099, 12'h010};

  initial begin
    rst_n = 1'b0; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_bcd2", 32'(bcd2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      issue(dir_bin[i], dir_bcd[i]);
      drain(40);
    end

    // Back-to-back: each new start lands in the DONE cycle of the previous one.
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      start = 1'b1;
      bin   = 8'(v);
      q1.push_back('{ref_bcd(v), cyc + 9});
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
    end
    drain(40);

    // Start during SHIFT must be ignored.
    issue(8'd200, 12'h200);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    chk("hold_bcd_idle", 32'(bcd), 32'h200);

    // Asynchronous reset in the 4th SHIFT cycle of 123.
    issue(8'd123, 12'h123);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done_q", 32'(q1.size()), 32'd0);
    issue(8'd45, 12'h045);
    drain(40);

    issue2(4'd15, 8'h15);
    drain(30);
    issue2(4'd9, 8'h09);
    drain(30);
    issue2(4'd0, 8'h00);
    drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
